// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: upstream sequencer for the 16-bit multi-cycle ALU.
// Takes one request (op, x, y) over valid/ready, pulses alu_start, drives
// x then y on alu_inbus, waits for alu_finish, captures flags (in the
// finish cycle) and result (one cycle later), then returns them on a
// valid/ready response channel.
//
// Ports
//   clk, rst_b                       clock, async active-low reset
//   req_valid/req_ready/req_op/x/y   request channel
//   alu_start, alu_s, alu_inbus      drive to the ALU
//   alu_outbus, alu_negative/zero/carry/overflow, alu_finish  from the ALU
//   rsp_valid/rsp_ready/rsp_result/rsp_flags/rsp_err          response channel
//   busy                             high in every state except IDLE
//
// Optional build macro: ALU_TIMEOUT_EN adds a WAIT-state timeout of
// TIMEOUT_CYC cycles that returns rsp_err=1 with zero result and flags.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a request, ALU bus parked at 0
// START   | one-cycle alu_start pulse, alu_s=op, alu_inbus=x
// LOAD_X  | x held on alu_inbus for LOAD_X_CYC cycles
// LOAD_Y  | y held on alu_inbus for LOAD_Y_CYC cycles
// WAIT    | y held, waiting for alu_finish (optionally bounded)
// CAPTURE | alu_outbus latched into rsp_result
// RESP    | rsp_valid high, payload stable until rsp_ready

module alu_seq_ctrl #(
   parameter int LOAD_X_CYC  = 1,
   parameter int LOAD_Y_CYC  = 1,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [15:0] req_x,
   input  logic [15:0] req_y,
   output logic        alu_start,
   output logic [3:0]  alu_s,
   output logic [15:0] alu_inbus,
   input  logic [15:0] alu_outbus,
   input  logic        alu_negative,
   input  logic        alu_zero,
   input  logic        alu_carry,
   input  logic        alu_overflow,
   input  logic        alu_finish,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [3:0]  rsp_flags,
   output logic        rsp_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_LOAD_X, S_LOAD_Y, S_WAIT, S_CAPTURE, S_RESP
   } state_t;

   state_t      state;
   logic [3:0]  phase_cnt;
   logic [15:0] y_q;
   logic [3:0]  flags_in;

   assign flags_in = {alu_negative, alu_zero, alu_carry, alu_overflow};

`ifdef ALU_TIMEOUT_EN
   logic [15:0] wait_cnt;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC != 0);
   assign rsp_err = 1'b0;
`endif

   // All outputs are registered: each transition sets the outputs that
   // belong to the state being entered.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state      <= S_IDLE;
         phase_cnt  <= '0;
         y_q        <= '0;
         req_ready  <= 1'b1;
         alu_start  <= 1'b0;
         alu_s      <= '0;
         alu_inbus  <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         busy       <= 1'b0;
`ifdef ALU_TIMEOUT_EN
         wait_cnt   <= '0;
         rsp_err    <= 1'b0;
`endif
      end else begin
         alu_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  alu_start <= 1'b1;
                  alu_s     <= req_op;
                  alu_inbus <= req_x;
                  y_q       <= req_y;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
`ifdef ALU_TIMEOUT_EN
                  rsp_err   <= 1'b0;
`endif
                  state     <= S_START;
               end
            end
            S_START: begin
               phase_cnt <= 4'(LOAD_X_CYC - 1);
               state     <= S_LOAD_X;
            end
            S_LOAD_X: begin
               if (alu_finish) begin
                  rsp_flags <= flags_in;
                  state     <= S_CAPTURE;
               end else if (phase_cnt == 4'd0) begin
                  phase_cnt <= 4'(LOAD_Y_CYC - 1);
                  alu_inbus <= y_q;
                  state     <= S_LOAD_Y;
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end
            S_LOAD_Y: begin
               if (alu_finish) begin
                  rsp_flags <= flags_in;
                  state     <= S_CAPTURE;
               end else if (phase_cnt == 4'd0) begin
`ifdef ALU_TIMEOUT_EN
                  wait_cnt  <= '0;
`endif
                  state     <= S_WAIT;
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end
            S_WAIT: begin
               // finish takes priority over a coincident timeout
               if (alu_finish) begin
                  rsp_flags <= flags_in;
                  state     <= S_CAPTURE;
               end
`ifdef ALU_TIMEOUT_EN
               else if (wait_cnt == 16'(TIMEOUT_CYC - 1)) begin
                  rsp_err    <= 1'b1;
                  rsp_result <= '0;
                  rsp_flags  <= '0;
                  rsp_valid  <= 1'b1;
                  alu_s      <= '0;
                  alu_inbus  <= '0;
                  state      <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
`endif
            end
            S_CAPTURE: begin
               // outbus is registered in the ALU, valid the cycle after finish
               rsp_result <= alu_outbus;
               rsp_valid  <= 1'b1;
               alu_s      <= '0;
               alu_inbus  <= '0;
               state      <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

   localparam int LX = 1;
   localparam int LY = 1;
   localparam int TO = 20;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = '0;
   logic [15:0] req_x = '0;
   logic [15:0] req_y = '0;
   logic        alu_start;
   logic [3:0]  alu_s;
   logic [15:0] alu_inbus;
   logic [15:0] alu_outbus = '0;
   logic        alu_negative = 1'b0;
   logic        alu_zero = 1'b0;
   logic        alu_carry = 1'b0;
   logic        alu_overflow = 1'b0;
   logic        alu_finish = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic        rsp_err;
   logic        busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.LOAD_X_CYC(LX), .LOAD_Y_CYC(LY), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_b(rst_b),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_x(req_x), .req_y(req_y),
      .alu_start(alu_start), .alu_s(alu_s), .alu_inbus(alu_inbus),
      .alu_outbus(alu_outbus), .alu_negative(alu_negative), .alu_zero(alu_zero),
      .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_finish(alu_finish),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one operation. Cycle n=1 is START (accept cycle is n=0); the ALU
   // model raises finish in cycle k+1, drives outbus only in cycle k+2 and
   // drives junk flags outside the finish cycle. rsp_ready rises 'hold'
   // cycles after rsp_valid is expected. keep leaves req_valid high.
   task automatic do_op(input string name, input logic [3:0] op, input logic [15:0] x,
                        input logic [15:0] y, input int k, input logic [15:0] res,
                        input logic [3:0] fl, input int hold, input bit keep);
      int last;
      last = k + 4 + hold;
      req_op = op; req_x = x; req_y = y; req_valid = 1'b1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL %s accept_ready: got %b want 1", name, req_ready);
      end
      tick();
      for (int n = 1; n <= last; n++) begin
         logic [15:0] e_in;
         if (n > 1) tick();
         if (!keep) req_valid = 1'b0;
         alu_finish = (n == k + 1);
         {alu_negative, alu_zero, alu_carry, alu_overflow} = (n == k + 1) ? fl : ~fl;
         alu_outbus = (n == k + 2) ? res : ~res;
         rsp_ready = (n == k + 3 + hold);
         e_in = (n <= 1 + LX) ? x : y;

         checks++;
         if (alu_start !== (n == 1)) begin
            errors++; $display("FAIL %s alu_start n=%0d: got %b want %b", name, n, alu_start, n == 1);
         end
         if (n <= k + 1) begin
            checks++;
            if (alu_inbus !== e_in) begin
               errors++; $display("FAIL %s alu_inbus n=%0d: got %h want %h", name, n, alu_inbus, e_in);
            end
         end
         if (n <= k + 2) begin
            checks++;
            if (alu_s !== op) begin
               errors++; $display("FAIL %s alu_s n=%0d: got %h want %h", name, n, alu_s, op);
            end
         end
         if (n <= k + 3 + hold) begin
            checks++;
            if (rsp_valid !== (n >= k + 3) || req_ready !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL %s handshake n=%0d: got valid=%b ready=%b busy=%b want valid=%b ready=0 busy=1",
                        name, n, rsp_valid, req_ready, busy, n >= k + 3);
            end
         end else begin
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || alu_s !== 4'h0) begin
               errors++;
               $display("FAIL %s post_resp: got valid=%b ready=%b busy=%b alu_s=%h want 0 1 0 0",
                        name, rsp_valid, req_ready, busy, alu_s);
            end
         end
         if (n >= k + 3 && n <= k + 3 + hold) begin
            checks++;
            if (rsp_result !== res || rsp_flags !== fl || rsp_err !== 1'b0) begin
               errors++;
               $display("FAIL %s payload n=%0d: got res=%h flags=%b err=%b want res=%h flags=%b err=0",
                        name, n, rsp_result, rsp_flags, rsp_err, res, fl);
            end
         end
      end
      alu_finish = 1'b0;
      rsp_ready = 1'b0;
      {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'b0000;
   endtask

   task automatic test_reset();
      bit bad_start, bad_inbus, bad_ready, bad_busy;
      #12;
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || alu_start !== 1'b0 ||
          alu_inbus !== 16'h0 || alu_s !== 4'h0 || rsp_result !== 16'h0 || rsp_flags !== 4'h0 ||
          rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: got ready=%b busy=%b valid=%b start=%b inbus=%h s=%h res=%h fl=%b err=%b",
                  req_ready, busy, rsp_valid, alu_start, alu_inbus, alu_s, rsp_result, rsp_flags, rsp_err);
      end
      tick();
      rst_b = 1'b1;
      bad_start = 0; bad_inbus = 0; bad_ready = 0; bad_busy = 0;
      for (int n = 0; n < 8; n++) begin
         tick();
         alu_finish = (n == 3);   // stray finish in IDLE must be ignored
         if (alu_start !== 1'b0) bad_start = 1;
         if (alu_inbus !== 16'h0) bad_inbus = 1;
         if (req_ready !== 1'b1) bad_ready = 1;
         if (busy !== 1'b0 || rsp_valid !== 1'b0) bad_busy = 1;
      end
      alu_finish = 1'b0;
      checks++;
      if (bad_start) begin errors++; $display("FAIL idle_start: got 1 want 0"); end
      checks++;
      if (bad_inbus) begin errors++; $display("FAIL idle_inbus: got nonzero want 0"); end
      checks++;
      if (bad_ready) begin errors++; $display("FAIL idle_ready: got 0 want 1"); end
      checks++;
      if (bad_busy) begin errors++; $display("FAIL idle_busy_valid: got 1 want 0"); end
   endtask

   task automatic test_add();
      do_op("add", 4'h0, 16'h0005, 16'h0003, 10, 16'h0008, 4'b0000, 0, 1'b0);
   endtask

   task automatic test_sub_backpressure();
      do_op("sub", 4'h1, 16'h0003, 16'h0003, 6, 16'h0000, 4'b0100, 5, 1'b0);
   endtask

   task automatic test_short_op();
      do_op("short_ly", 4'h7, 16'h8000, 16'h7FFF, LX + 1, 16'hFFFF, 4'b1000, 0, 1'b0);
      do_op("short_lx", 4'h9, 16'h1111, 16'h2222, 1, 16'hA5A5, 4'b0011, 1, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_op("b2b_1", 4'h2, 16'h00F0, 16'h0FF0, 5, 16'h00F0, 4'b0000, 2, 1'b1);
      do_op("b2b_2", 4'h3, 16'h1234, 16'h4321, 4, 16'h5555, 4'b0010, 0, 1'b0);
   endtask

`ifdef ALU_TIMEOUT_EN
   task automatic test_timeout();
      int resp_n;
      req_op = 4'h5; req_x = 16'h0101; req_y = 16'h0202; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      // START n=1, LOAD_X n=2, LOAD_Y n=3, WAIT n=4..3+TO, RESP n=4+TO
      resp_n = 0;
      for (int n = 1; n <= 4 + TO + 5 && resp_n == 0; n++) begin
         if (n > 1) tick();
         if (rsp_valid === 1'b1) resp_n = n;
      end
      checks++;
      if (resp_n != 4 + TO) begin
         errors++; $display("FAIL timeout_latency: got n=%0d want n=%0d", resp_n, 4 + TO);
      end
      checks++;
      if (rsp_err !== 1'b1 || rsp_result !== 16'h0 || rsp_flags !== 4'h0) begin
         errors++; $display("FAIL timeout_payload: got err=%b res=%h fl=%b want 1 0000 0000",
                            rsp_err, rsp_result, rsp_flags);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL timeout_release: got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
      end
   endtask
`endif

   task automatic test_reset_mid_wait();
      bit seen;
      req_op = 4'hC; req_x = 16'h0F0F; req_y = 16'hF0F0; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (5) tick();   // now in WAIT
      checks++;
      if (busy !== 1'b1 || alu_inbus !== 16'hF0F0) begin
         errors++; $display("FAIL wait_state: got busy=%b inbus=%h want 1 f0f0", busy, alu_inbus);
      end
      rst_b = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || alu_start !== 1'b0 ||
          alu_inbus !== 16'h0 || alu_s !== 4'h0 || rsp_result !== 16'h0 || rsp_flags !== 4'h0) begin
         errors++;
         $display("FAIL async_reset: got ready=%b busy=%b valid=%b start=%b inbus=%h s=%h res=%h fl=%b",
                  req_ready, busy, rsp_valid, alu_start, alu_inbus, alu_s, rsp_result, rsp_flags);
      end
      tick();
      rst_b = 1'b1;
      seen = 0;
      for (int n = 0; n < 30; n++) begin
         tick();
         alu_finish = (n == 2);
         alu_outbus = 16'hBEEF;
         if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1;
      end
      alu_finish = 1'b0;
      checks++;
      if (seen) begin errors++; $display("FAIL no_rsp_after_reset: got activity want none"); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_add();
      test_sub_backpressure();
      test_short_op();
      test_back_to_back();
`ifdef ALU_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Upstream sequencer for the 16-bit multi-cycle ALU. It accepts one operation request (opcode plus two operands) over a valid/ready handshake and pulses the ALU start. It drives the ALU select and operand bus in the required phase order, waits for ALU finish, and captures the result and flags. It returns them over a valid/ready response channel, so it decouples the register file/bus master from ALU timing.

Parameters:
LOAD_X_CYC, 1, cycles operand X is held on alu_inbus after the start cycle (range 1-15)
LOAD_Y_CYC, 1, cycles operand Y is held on alu_inbus before entering WAIT (range 1-15)
TIMEOUT_CYC, 255, WAIT-state cycle limit; used only with ALU_TIMEOUT_EN (range 1-65535)

Ports:
clk  in  1  system clock, rising edge
rst_b  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer accepts request
req_op  in  4  ALU operation select
req_x  in  16  first operand
req_y  in  16  second operand
alu_start  out  1  one-cycle start pulse to ALU
alu_s  out  4  ALU select, held stable for the whole operation
alu_inbus  out  16  ALU operand bus
alu_outbus  in  16  ALU registered result
alu_negative, alu_zero, alu_carry, alu_overflow  in  1 each  ALU flags
alu_finish  in  1  ALU done
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  16  captured result
rsp_flags  out  4  captured {N,Z,C,V}
rsp_err  out  1  operation aborted by timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE, all outputs 0 except req_ready=1. Op, operand, result and flag registers are cleared. Reset mid-operation aborts immediately; no response is produced.
- IDLE: req_ready=1.
  - On req_valid & req_ready, latch op/x/y and go to START.
  - alu_inbus=0 and alu_s=0 in IDLE.
- START (1 cycle): alu_start=1, alu_s=op, alu_inbus=x. Then go to LOAD_X.
- LOAD_X: alu_inbus=x for LOAD_X_CYC cycles (down-counter), then go to LOAD_Y.
- LOAD_Y: alu_inbus=y for LOAD_Y_CYC cycles, then go to WAIT.
- WAIT: alu_inbus=y held. alu_s=op is held from START through CAPTURE.
- alu_finish sampled high in LOAD_X, LOAD_Y or WAIT (short ops): latch the four flag inputs into rsp_flags in that same cycle, then go to CAPTURE.
- CAPTURE (1 cycle): latch alu_outbus into rsp_result (the ALU outbus is registered and valid one cycle after finish). Then go to RESP.
- RESP: rsp_valid=1 with result, flags and err stable.
  - On rsp_ready, go to IDLE.
  - req_ready=0 in RESP; no request is accepted until the response is taken.
- alu_finish outside LOAD_X/LOAD_Y/WAIT is ignored. alu_start is never asserted outside START.
- Latency with immediate rsp_ready and ALU finish k cycles after start, for k > LOAD_X_CYC+LOAD_Y_CYC:
  - accept-to-rsp_valid = k+3 cycles.
  - rsp_valid lasts 1 cycle.
  - next req_ready is high the cycle after the response handshake.
- Back-pressure: rsp_valid is held indefinitely with no payload change.
- rsp_err=0 unless the optional feature fires.

Optional Feature:
- Macro ALU_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without alu_finish, go directly to RESP with rsp_err=1, rsp_result=0 and rsp_flags=0.
  - finish and timeout in the same cycle: finish wins.
- When undefined: no counter is built, WAIT is unbounded and rsp_err is tied to 0.

Test Plan:
- Reset held, then released with no request → req_ready=1, busy=0, rsp_valid=0, alu_start never asserted, alu_inbus=0.
- ADD op=0000, x=0x0005, y=0x0003; ALU model finishes 10 cycles after start with outbus 0x0008 → alu_start pulses once, inbus=5 in START plus 1 cycle, then 3; rsp_result=0x0008, flags N=0 Z=1? no: Z=0; rsp_valid at accept+13.
- SUB x=0x0003, y=0x0003 → rsp_result=0x0000, rsp_flags Z=1, N=0; rsp_ready held low 5 cycles → rsp_valid and payload stable for all 5, req_ready=0 throughout.
- ALU model asserts finish during LOAD_Y (short op, outbus 0xFFFF, N=1) → goes straight to CAPTURE; rsp_result=0xFFFF, N=1.
- Back-to-back requests with req_valid held high → second accept only after the first response handshake; the second op's alu_s is applied only from its START.
- rst_b pulsed low during WAIT → all outputs return to reset values immediately, no rsp_valid follows. With ALU_TIMEOUT_EN and TIMEOUT_CYC=20 and no finish: rsp_valid with rsp_err=1 and result 0 after 20 WAIT cycles.
